// File: rtl/sid_pkg.sv
// Shared definitions for the SID-style three-voice mixer.
// Contents: datapath width constants, shared-multiplier operand widths,
// the default product shift, and the mixer FSM state encoding.
package sid_pkg;

  localparam int unsigned WaveW   = 12;  // signed voice waveform
  localparam int unsigned EnvW    = 8;   // unsigned voice envelope
  localparam int unsigned VolW    = 4;   // unsigned master volume
  localparam int unsigned SampleW = 16;  // signed mixed sample / accumulator

  localparam int unsigned MulAW = 18;    // signed multiplier operand A
  localparam int unsigned MulBW = 9;     // signed multiplier operand B
  localparam int unsigned MulPW = 27;    // signed product

  localparam int unsigned ProdShiftDefault = 7;

  typedef enum logic [2:0] {
    StIdle,
    StV1,
    StV2,
    StV3,
    StVol
  } state_e;

endpackage

// File: rtl/mul_18x9.sv
// Purely combinational signed 18x9 multiplier with a full-width 27-bit product.
// Ports:
//   i_a  in  18  signed operand A
//   i_b  in  9   signed operand B
//   o_p  out 27  signed product A*B
module mul_18x9
  import sid_pkg::*;
(
  input  logic signed [MulAW-1:0] i_a,
  input  logic signed [MulBW-1:0] i_b,
  output logic signed [MulPW-1:0] o_p
);

  logic signed [MulPW-1:0] w_a;
  logic signed [MulPW-1:0] w_b;

  always_comb begin
    w_a = {{(MulPW - MulAW){i_a[MulAW-1]}}, i_a};
    w_b = {{(MulPW - MulBW){i_b[MulBW-1]}}, i_b};
    // 18x9 signed fits in 26 bits plus sign, so the truncated product is exact.
    o_p = w_a * w_b;
  end

endmodule

// File: rtl/sid_mix_seq.sv
// Sequential three-voice mixer. A strobe starts a five-state sequence that
// reuses one 18x9 multiplier: each voice's wave x envelope product is shifted
// and accumulated (V1..V3), then the accumulator is scaled by master volume
// (VOL) and registered as the output sample.
// Ports:
//   clk              in   1   system clock
//   rst              in   1   synchronous active-high reset
//   clk_1mhz_ph1_en  in   1   strobe starting a mix sequence
//   i_wave1..3       in   12  signed voice waveforms
//   i_env1..3        in   8   unsigned voice envelopes
//   i_volume         in   4   unsigned master volume
//   i_voice3_off     in   1   mute voice 3 in the mix
//   o_sample         out  16  signed mixed sample, held between updates
//   o_valid          out  1   one-cycle pulse when o_sample updates
//   o_overrun        out  1   one-cycle pulse for a strobe seen mid-sequence
module sid_mix_seq
  import sid_pkg::*;
#(
  parameter int unsigned PROD_SHIFT = ProdShiftDefault
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_1mhz_ph1_en,
  input  logic signed [WaveW-1:0]   i_wave1,
  input  logic signed [WaveW-1:0]   i_wave2,
  input  logic signed [WaveW-1:0]   i_wave3,
  input  logic        [EnvW-1:0]    i_env1,
  input  logic        [EnvW-1:0]    i_env2,
  input  logic        [EnvW-1:0]    i_env3,
  input  logic        [VolW-1:0]    i_volume,
  input  logic                      i_voice3_off,
  output logic signed [SampleW-1:0] o_sample,
  output logic                      o_valid,
  output logic                      o_overrun
);

  state_e                    r_state;
  logic signed [SampleW-1:0] r_acc;
  logic signed [SampleW-1:0] r_sample;
  logic                      r_valid;
  logic                      r_overrun;

  logic signed [MulAW-1:0]   w_mul_a;
  logic signed [MulBW-1:0]   w_mul_b;
  logic signed [MulPW-1:0]   w_prod;
  logic signed [MulPW-1:0]   w_prod_shr;
  logic signed [SampleW-1:0] w_term;
  logic signed [SampleW-1:0] w_term3;
  logic                      w_unused_prod;

  // Operand steering for the single shared multiplier.
  always_comb begin
    w_mul_a = {{(MulAW - SampleW){r_acc[SampleW-1]}}, r_acc};
    w_mul_b = {{(MulBW - VolW){1'b0}}, i_volume};
    unique case (r_state)
      StV1: begin
        w_mul_a = {{(MulAW - WaveW){i_wave1[WaveW-1]}}, i_wave1};
        w_mul_b = {1'b0, i_env1};
      end
      StV2: begin
        w_mul_a = {{(MulAW - WaveW){i_wave2[WaveW-1]}}, i_wave2};
        w_mul_b = {1'b0, i_env2};
      end
      StV3: begin
        w_mul_a = {{(MulAW - WaveW){i_wave3[WaveW-1]}}, i_wave3};
        w_mul_b = {1'b0, i_env3};
      end
      default: ;
    endcase
  end

  mul_18x9 u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  // Shifted voice term fits in 16 bits for the default shift, so truncation is lossless.
  always_comb begin
    w_prod_shr = w_prod >>> PROD_SHIFT;
    w_term     = w_prod_shr[SampleW-1:0];
    w_term3    = i_voice3_off ? '0 : w_term;
  end

  assign w_unused_prod = ^{w_prod[MulPW-1:20], w_prod[3:0], w_prod_shr[MulPW-1:SampleW]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_acc     <= '0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      // A strobe outside IDLE is dropped; only the flag records it.
      r_overrun <= clk_1mhz_ph1_en && (r_state != StIdle);
      unique case (r_state)
        StIdle: begin
          if (clk_1mhz_ph1_en) r_state <= StV1;
        end
        StV1: begin
          r_acc   <= w_term;
          r_state <= StV2;
        end
        StV2: begin
          r_acc   <= r_acc + w_term;
          r_state <= StV3;
        end
        StV3: begin
          r_acc   <= r_acc + w_term3;
          r_state <= StVol;
        end
        StVol: begin
          // acc x vol / 16
          r_sample <= w_prod[19:4];
          r_valid  <= 1'b1;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_sample  = r_sample;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_sid_mix_seq.sv
module tb_sid_mix_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_1mhz_ph1_en;
  logic [11:0] i_wave1, i_wave2, i_wave3;
  logic [7:0]  i_env1, i_env2, i_env3;
  logic [3:0]  i_volume;
  logic        i_voice3_off;
  logic [15:0] o_sample;
  logic        o_valid;
  logic        o_overrun;

  sid_mix_seq #(.PROD_SHIFT(7)) dut (
    .clk             (clk),
    .rst             (rst),
    .clk_1mhz_ph1_en (clk_1mhz_ph1_en),
    .i_wave1         (i_wave1),
    .i_wave2         (i_wave2),
    .i_wave3         (i_wave3),
    .i_env1          (i_env1),
    .i_env2          (i_env2),
    .i_env3          (i_env3),
    .i_volume        (i_volume),
    .i_voice3_off    (i_voice3_off),
    .o_sample        (o_sample),
    .o_valid         (o_valid),
    .o_overrun       (o_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] sample;
  } exp_t;

  exp_t expq[$];
  int   ovq[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  bit   prev_rst = 1'b1;
  logic [15:0] last_sample = 16'h0000;
  int   last_acc = -100;

  // Reference: signed wave x unsigned envelope, floor-shifted by 7, summed,
  // scaled by volume/16 (floor).
  function automatic logic [15:0] model();
    int t1, t2, t3, acc, s;
    t1  = (int'($signed(i_wave1)) * int'(i_env1)) >>> 7;
    t2  = (int'($signed(i_wave2)) * int'(i_env2)) >>> 7;
    t3  = i_voice3_off ? 0 : ((int'($signed(i_wave3)) * int'(i_env3)) >>> 7);
    acc = t1 + t2 + t3;
    s   = (acc * int'(i_volume)) >>> 4;
    return s[15:0];
  endfunction

  // Drive one cycle; exp_s < 0 means take the expected sample from the model.
  task automatic drive(input bit stb, input bit r, input int exp_s);
    exp_t e;
    clk_1mhz_ph1_en = stb;
    rst             = r;
    if (r) begin
      last_acc = -100;
    end else if (stb) begin
      if (cyc >= last_acc + 1 && cyc <= last_acc + 4) begin
        ovq.push_back(cyc + 1);
      end else begin
        last_acc = cyc;
        e.cyc    = cyc + 5;
        e.sample = (exp_s < 0) ? model() : exp_s[15:0];
        expq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [11:0] w1, input logic [11:0] w2, input logic [11:0] w3,
                        input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                        input logic [3:0] vol, input logic v3off);
    i_wave1 = w1; i_wave2 = w2; i_wave3 = w3;
    i_env1 = e1; i_env2 = e2; i_env3 = e3;
    i_volume = vol; i_voice3_off = v3off;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, -1);
  endtask

  // Monitor / scoreboard checker.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_ov;
    if (mon_en) begin
      if (prev_rst) last_sample = 16'h0000;
      if (o_valid) begin
        checks++;
        if (expq.size() != 0 && expq[0].cyc == cyc) begin
          e = expq.pop_front();
          if (o_sample !== e.sample) begin
            failures++;
            $display("FAIL sample cyc=%0d got=%h want=%h", cyc, o_sample, e.sample);
          end
          last_sample = e.sample;
        end else begin
          failures++;
          $display("FAIL unexpected_valid cyc=%0d got=1 want=0", cyc);
          last_sample = o_sample;
        end
      end else begin
        if (expq.size() != 0 && expq[0].cyc <= cyc) begin
          checks++;
          failures++;
          $display("FAIL missing_valid cyc=%0d got=0 want=1", cyc);
          void'(expq.pop_front());
        end
        checks++;
        if (o_sample !== last_sample) begin
          failures++;
          $display("FAIL hold cyc=%0d got=%h want=%h", cyc, o_sample, last_sample);
        end
      end
      exp_ov = (ovq.size() != 0 && ovq[0] == cyc);
      if (exp_ov) void'(ovq.pop_front());
      checks++;
      if (o_overrun !== exp_ov) begin
        failures++;
        $display("FAIL overrun cyc=%0d got=%b want=%b", cyc, o_overrun, exp_ov);
      end
      // Synchronous reset aborts anything still in flight.
      if (rst) begin
        while (expq.size() != 0 && expq[expq.size()-1].cyc > cyc) void'(expq.pop_back());
      end
      prev_rst = rst;
    end
  end

  initial begin
    rst             = 1'b1;
    clk_1mhz_ph1_en = 1'b0;
    set_in(12'h0, 12'h0, 12'h0, 8'h0, 8'h0, 8'h0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    drive(1'b0, 1'b1, -1);
    drive(1'b0, 1'b1, -1);
    idle(2);

    // Full-scale positive voice 1.
    set_in(12'h7FF, 12'h123, 12'h456, 8'hFF, 8'h00, 8'h00, 4'hF, 1'b0);
    drive(1'b1, 1'b0, 'h0EEF);
    idle(4);
    // Full-scale negative voice 1.
    set_in(12'h800, 12'h321, 12'h654, 8'hFF, 8'h00, 8'h00, 4'hF, 1'b0);
    drive(1'b1, 1'b0, 'hF10F);
    idle(4);
    // Zero volume still pulses valid.
    set_in(12'h7FF, 12'h000, 12'h000, 8'hFF, 8'h00, 8'h00, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 'h0000);
    idle(4);
    // Voice 3 muted, then unmuted.
    set_in(12'h000, 12'h000, 12'h7FF, 8'h00, 8'h00, 8'hFF, 4'hF, 1'b1);
    drive(1'b1, 1'b0, 'h0000);
    idle(4);
    i_voice3_off = 1'b0;
    drive(1'b1, 1'b0, 'h0EEF);
    idle(5);
    // Strobe mid-sequence: overrun at T+3, one valid at T+5.
    set_in(12'h7FF, 12'h000, 12'h000, 8'hFF, 8'h00, 8'h00, 4'hF, 1'b0);
    drive(1'b1, 1'b0, 'h0EEF);
    drive(1'b0, 1'b0, -1);
    drive(1'b1, 1'b0, -1);
    idle(4);
    // Reset at T+2 aborts; following strobe completes.
    set_in(12'h7FF, 12'h000, 12'h000, 8'hFF, 8'h00, 8'h00, 4'hF, 1'b0);
    drive(1'b1, 1'b0, 'h0EEF);
    drive(1'b0, 1'b0, -1);
    drive(1'b0, 1'b1, -1);
    idle(5);
    // Reset wins over a simultaneous strobe.
    drive(1'b1, 1'b1, -1);
    idle(2);
    drive(1'b1, 1'b0, 'h0EEF);
    idle(5);

    // Randomized sequences with occasional mid-sequence strobes.
    for (int n = 0; n < 60; n++) begin
      set_in(12'($urandom), 12'($urandom), 12'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
      drive(1'b1, 1'b0, -1);
      for (int k = 0; k < 4; k++) drive(($urandom_range(0, 5) == 0), 1'b0, -1);
      idle($urandom_range(0, 2));
    end

    idle(8);
    checks++;
    if (expq.size() != 0 || ovq.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d/%0d pending want=0/0", expq.size(), ovq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
